// File: rtl/uart_tx_tick_if.sv
// Handshake and serial-line bundle for uart_tx_tick.
// master = word source / line observer, slave = the transmitter.
interface uart_tx_tick_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 i_tick;
  logic [DATA_BITS-1:0] i_data;
  logic                 i_valid;
  logic                 o_ready;
  logic                 o_tx;
  logic                 o_busy;
  logic                 o_done;

  modport master (
    output i_tick, i_data, i_valid,
    input  o_ready, o_tx, o_busy, o_done
  );

  modport slave (
    input  i_tick, i_data, i_valid,
    output o_ready, o_tx, o_busy, o_done
  );
endinterface

// File: rtl/uart_tx_tick.sv
// uart_tx_tick: UART-style serial transmitter.
// Bit timing comes from an external one-cycle tick (mod-k counter roll-over).
// It accepts one word per frame via valid/ready.
// The frame is shifted out as: start, data LSB-first, optional parity, stop bit(s).
// All outputs are registered, and the line only changes on the cycle after a tick.
module uart_tx_tick #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0
) (
  input logic           i_clk,
  input logic           i_reset,
  uart_tx_tick_if.slave bus
);

  localparam int unsigned      CNT_W     = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t               state_q,    state_d;
  logic [DATA_BITS-1:0] shift_q,    shift_d;
  logic                 parity_q,   parity_d;
  logic [CNT_W-1:0]     bit_cnt_q,  bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 tx_q,       tx_d;
  logic                 ready_q,    ready_d;
  logic                 busy_q,     busy_d;
  logic                 done_q,     done_d;

  // Next-state and next-output logic; every transition except accept waits for a tick.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    tx_d       = tx_q;
    ready_d    = ready_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        // A tick in the accept cycle is deliberately not acted on: ALIGN waits for the next one.
        if (bus.i_valid && ready_q) begin
          shift_d  = bus.i_data;
          parity_d = (^bus.i_data) ^ (PARITY_ODD != 0);
          ready_d  = 1'b0;
          busy_d   = 1'b1;
          state_d  = ALIGN;
        end
      end
      ALIGN: begin
        if (bus.i_tick) begin
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (bus.i_tick) begin
          tx_d      = shift_q[0];
          bit_cnt_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (bus.i_tick) begin
          if (bit_cnt_q == LAST_BIT) begin
            stop_cnt_d = 1'b0;
            if (PARITY_EN != 0) begin
              tx_d    = parity_q;
              state_d = PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = STOP;
            end
          end else begin
            // The line already shows shift_q[0], so bit 1 is the one that goes out next.
            tx_d      = shift_q[1];
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (bus.i_tick) begin
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
          state_d    = STOP;
        end
      end
      STOP: begin
        if (bus.i_tick) begin
          if (stop_cnt_q == LAST_STOP) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            ready_d = 1'b1;
            state_d = IDLE;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; synchronous reset drops any frame in flight.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.o_tx    = tx_q;
  assign bus.o_ready = ready_q;
  assign bus.o_busy  = busy_q;
  assign bus.o_done  = done_q;

endmodule

// File: tb/tb_uart_tx_tick.sv
// Testbench for uart_tx_tick.
// Three configurations are exercised side by side: 8N1, 8E2 and 9O1.
// The shared tick strobe has a programmable period.
module tb_uart_tx_tick;

  localparam int unsigned NDUT = 3;
  localparam int unsigned CFG_D [NDUT] = '{8, 8, 9};
  localparam int unsigned CFG_S [NDUT] = '{1, 2, 1};
  localparam int unsigned CFG_P [NDUT] = '{0, 1, 1};
  localparam int unsigned CFG_O [NDUT] = '{0, 0, 1};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  int         tick_period = 4;
  int         tick_cnt = 0;
  logic       valid [NDUT];
  logic [8:0] data  [NDUT];
  logic       tx_o [NDUT], ready_o [NDUT], busy_o [NDUT], done_o [NDUT];

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  bit          sb_en = 1'b0;

  uart_tx_tick_if #(.DATA_BITS(8)) if0 ();
  uart_tx_tick_if #(.DATA_BITS(8)) if1 ();
  uart_tx_tick_if #(.DATA_BITS(9)) if2 ();

  uart_tx_tick #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_EN(0), .PARITY_ODD(0))
    u_dut0 (.i_clk(clk), .i_reset(rst), .bus(if0));
  uart_tx_tick #(.DATA_BITS(8), .STOP_BITS(2), .PARITY_EN(1), .PARITY_ODD(0))
    u_dut1 (.i_clk(clk), .i_reset(rst), .bus(if1));
  uart_tx_tick #(.DATA_BITS(9), .STOP_BITS(1), .PARITY_EN(1), .PARITY_ODD(1))
    u_dut2 (.i_clk(clk), .i_reset(rst), .bus(if2));

  assign if0.i_tick  = tick;
  assign if1.i_tick  = tick;
  assign if2.i_tick  = tick;
  assign if0.i_valid = valid[0];
  assign if1.i_valid = valid[1];
  assign if2.i_valid = valid[2];
  assign if0.i_data  = data[0][7:0];
  assign if1.i_data  = data[1][7:0];
  assign if2.i_data  = data[2];

  assign tx_o[0] = if0.o_tx;  assign ready_o[0] = if0.o_ready;
  assign busy_o[0] = if0.o_busy;  assign done_o[0] = if0.o_done;
  assign tx_o[1] = if1.o_tx;  assign ready_o[1] = if1.o_ready;
  assign busy_o[1] = if1.o_busy;  assign done_o[1] = if1.o_done;
  assign tx_o[2] = if2.o_tx;  assign ready_o[2] = if2.o_ready;
  assign busy_o[2] = if2.o_busy;  assign done_o[2] = if2.o_done;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Tick strobe: high one cycle in every tick_period (constant high when the period is 1).
  initial forever begin
    @(negedge clk);
    if (tick_cnt + 1 >= tick_period) begin
      tick_cnt = 0;
      tick = 1'b1;
    end else begin
      tick_cnt++;
      tick = 1'b0;
    end
  end

  // Reference model: a frame is a list of line levels indexed by the number of ticks since accept.
  function automatic logic [15:0] build_frame(input int unsigned u, input logic [8:0] w);
    logic [15:0] f;
    logic        par;
    f    = '1;
    f[0] = 1'b0;
    par  = (CFG_O[u] != 0);
    for (int b = 0; b < int'(CFG_D[u]); b++) begin
      f[1 + b] = w[b];
      par      = par ^ w[b];
    end
    if (CFG_P[u] != 0) f[CFG_D[u] + 1] = par;
    return f;
  endfunction

  bit          m_active [NDUT];
  int unsigned m_n      [NDUT];
  logic [15:0] m_frame  [NDUT];
  logic        e_tx [NDUT], e_ready [NDUT], e_busy [NDUT], e_done [NDUT];

  initial forever begin
    @(posedge clk);
    for (int u = 0; u < NDUT; u++) begin
      if (rst) begin
        m_active[u] = 1'b0;
        m_n[u]      = 0;
        e_tx[u]     = 1'b1;
        e_ready[u]  = 1'b1;
        e_busy[u]   = 1'b0;
        e_done[u]   = 1'b0;
      end else begin
        e_done[u] = 1'b0;
        if (!m_active[u]) begin
          if (valid[u]) begin
            m_active[u] = 1'b1;
            m_n[u]      = 0;
            m_frame[u]  = build_frame(u, data[u]);
            e_ready[u]  = 1'b0;
            e_busy[u]   = 1'b1;
          end
        end else if (tick) begin
          m_n[u]++;
          if (m_n[u] == 2 + CFG_D[u] + CFG_P[u] + CFG_S[u]) begin
            m_active[u] = 1'b0;
            e_done[u]   = 1'b1;
            e_ready[u]  = 1'b1;
            e_busy[u]   = 1'b0;
            e_tx[u]     = 1'b1;
          end else if (m_n[u] <= 1 + CFG_D[u] + CFG_P[u]) begin
            e_tx[u] = m_frame[u][m_n[u] - 1];
          end else begin
            e_tx[u] = 1'b1;
          end
        end
      end
    end
  end

  // Scoreboard: every output of every instance against the model, mid-cycle.
  initial forever begin
    @(negedge clk);
    if (sb_en) begin
      for (int u = 0; u < NDUT; u++) begin
        chk($sformatf("sb%0d_tx", u),    tx_o[u],    e_tx[u]);
        chk($sformatf("sb%0d_ready", u), ready_o[u], e_ready[u]);
        chk($sformatf("sb%0d_busy", u),  busy_o[u],  e_busy[u]);
        chk($sformatf("sb%0d_done", u),  done_o[u],  e_done[u]);
      end
    end
  end

  // Send one word and record the line level just after each tick, in time order.
  task automatic send_capture(input int unsigned u, input logic [8:0] w, input int unsigned nbits,
                              output logic [0:15] got, output int unsigned dcnt);
    int unsigned idx, guard;
    logic t;
    got = '1; idx = 0; guard = 0; dcnt = 0;
    @(negedge clk); valid[u] = 1'b1; data[u] = w;
    @(negedge clk); valid[u] = 1'b0;
    while (idx < nbits && guard < 400) begin
      @(posedge clk); t = tick;
      @(negedge clk); guard++;
      if (done_o[u]) dcnt++;
      if (t) begin
        got[idx] = tx_o[u];
        idx++;
      end
    end
    if (idx < nbits) chk("capture_timeout", idx, nbits);
    repeat (40) begin
      @(negedge clk);
      if (done_o[u]) dcnt++;
    end
  endtask

  typedef struct {
    int unsigned dut;
    int          k;
    logic [8:0]  data;
    int unsigned nbits;
    logic [0:15] bits;
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic [0:15] got;
    int unsigned dc, hi, guard, n;
    logic        t, prev, seen;
    int          cyc, fall, dcyc;

    // Each table entry lists the expected line bits in time order, padded with 1s.
    vecs[0] = '{0, 4, 9'h0A5, 10, 16'b0101001011_111111};
    vecs[1] = '{1, 4, 9'h0A5, 12, 16'b010100101011_1111};
    vecs[2] = '{1, 4, 9'h001, 12, 16'b010000000111_1111};
    vecs[3] = '{2, 4, 9'h0A5, 12, 16'b010100101011_1111};
    vecs[4] = '{0, 1, 9'h03C, 10, 16'b0001111001_111111};
    vecs[5] = '{2, 3, 9'h1FF, 12, 16'b011111111101_1111};
    vecs[6] = '{0, 2, 9'h000, 10, 16'b0000000001_111111};
    vecs[7] = '{1, 1, 9'h0FF, 12, 16'b011111111011_1111};

    for (int u = 0; u < NDUT; u++) begin
      valid[u] = 1'b0;
      data[u]  = '0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    sb_en = 1'b1;
    for (int u = 0; u < NDUT; u++) begin
      chk("reset_tx",    tx_o[u],    1);
      chk("reset_ready", ready_o[u], 1);
      chk("reset_busy",  busy_o[u],  0);
      chk("reset_done",  done_o[u],  0);
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      tick_period = vecs[i].k;
      repeat (6) @(negedge clk);
      send_capture(vecs[i].dut, vecs[i].data, vecs[i].nbits, got, dc);
      chk($sformatf("vec%0d_bits", i), got, vecs[i].bits);
      chk($sformatf("vec%0d_done_count", i), dc, 1);
    end

    // Word offered while busy must be ignored and leave the frame intact.
    tick_period = 4;
    repeat (6) @(negedge clk);
    fork
      send_capture(0, 9'h0A5, 10, got, dc);
      begin
        repeat (14) @(negedge clk);
        chk("busy_ready_low", ready_o[0], 0);
        valid[0] = 1'b1; data[0] = 9'h0FF;
        @(negedge clk); valid[0] = 1'b0;
      end
    join
    chk("busy_frame_bits", got, 16'b0101001011_111111);
    chk("busy_done_count", dc, 1);

    // Back-to-back on 8E2 with valid held: two stop ticks, then start on the next tick.
    repeat (6) @(negedge clk);
    valid[1] = 1'b1; data[1] = 9'h05A;
    @(negedge clk); data[1] = 9'h0C3;
    hi = 0; prev = 1'b1; guard = 0; seen = 1'b0;
    while (!seen && guard < 600) begin
      @(posedge clk); t = tick;
      @(negedge clk); guard++;
      if (t) begin
        if (tx_o[1] && !prev) hi = 0;
        else if (tx_o[1]) hi++;
        prev = tx_o[1];
      end
      if (done_o[1]) seen = 1'b1;
    end
    chk("b2b_done_seen", seen, 1);
    chk("b2b_stop_ticks", hi, 2);
    chk("b2b_ready_at_done", ready_o[1], 1);
    @(negedge clk); valid[1] = 1'b0;
    chk("b2b_second_accept", busy_o[1], 1);
    t = 1'b0; guard = 0;
    while (!t && guard < 20) begin
      @(posedge clk); t = tick;
      @(negedge clk); guard++;
    end
    chk("b2b_second_start", tx_o[1], 0);
    guard = 0;
    while (busy_o[1] && guard < 200) begin
      @(negedge clk); guard++;
    end
    chk("b2b_second_end", busy_o[1], 0);

    // Reset while data bit 3 is on the line.
    repeat (6) @(negedge clk);
    valid[0] = 1'b1; data[0] = 9'h0A5;
    @(negedge clk); valid[0] = 1'b0;
    n = 0; guard = 0;
    while (n < 5 && guard < 100) begin
      @(posedge clk); t = tick;
      @(negedge clk); guard++;
      if (t) n++;
    end
    chk("rst_mid_bit3", tx_o[0], 0);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("rst_mid_tx",    tx_o[0],    1);
    chk("rst_mid_ready", ready_o[0], 1);
    chk("rst_mid_busy",  busy_o[0],  0);
    dc = 0;
    repeat (60) begin
      @(negedge clk);
      if (done_o[0]) dc++;
    end
    chk("rst_mid_no_done", dc, 0);

    // Tick every cycle: start bit to done pulse spans exactly the 10 bit-cycles of 8N1.
    tick_period = 1;
    repeat (4) @(negedge clk);
    valid[0] = 1'b1; data[0] = 9'h03C;
    @(negedge clk); valid[0] = 1'b0;
    cyc = 0; fall = -1; dcyc = -1;
    while (dcyc < 0 && cyc < 100) begin
      @(negedge clk); cyc++;
      if (fall < 0 && !tx_o[0]) fall = cyc;
      if (done_o[0]) dcyc = cyc;
    end
    chk("k1_frame_cycles", dcyc - fall, 10);

    // Random traffic, tick periods and occasional resets against the model.
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      if (c % 500 == 0) tick_period = int'($urandom_range(1, 5));
      for (int u = 0; u < NDUT; u++) begin
        valid[u] = ($urandom_range(0, 3) == 0);
        data[u]  = 9'($urandom);
      end
      rst = ($urandom_range(0, 499) == 0);
    end
    for (int u = 0; u < NDUT; u++) valid[u] = 1'b0;
    rst = 1'b0;
    repeat (300) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
